// File: rtl/ysyx_23060236_icache_refill_pkg.sv
// I-cache refill shared definitions: line geometry, AXI encodings, FSM states.
// Latency: n/a (constants and pure helper functions only).
// Backpressure: n/a.
//
// The line geometry lives here so that the cache and its refill controller
// cannot disagree about line size or word indexing.
package ysyx_23060236_icache_refill_pkg;

    localparam int ICACHE_ADDR_LEN   = 25;
    localparam int ICACHE_OFFSET_LEN = 5;
    localparam int ICACHE_DATA_LEN   = 32;
    localparam int ICACHE_CNT_LEN    = ICACHE_OFFSET_LEN - 2;
    localparam int ICACHE_BLOCK_SIZE = 2 ** ICACHE_CNT_LEN;

    localparam logic [31:0] ICACHE_MEM_BASE = 32'hA000_0000;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_AR    = 3'd1,
        S_R     = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } refill_state_t;

    // Line-aligned base of a fetch address.
    function automatic logic [ICACHE_ADDR_LEN-1:0] line_base(
        input logic [ICACHE_ADDR_LEN-1:0] addr
    );
        return {addr[ICACHE_ADDR_LEN-1:ICACHE_OFFSET_LEN], {ICACHE_OFFSET_LEN{1'b0}}};
    endfunction

    // Byte address of word 'idx' within the line containing 'line'.
    function automatic logic [ICACHE_ADDR_LEN-1:0] word_addr(
        input logic [ICACHE_ADDR_LEN-1:0] line,
        input logic [ICACHE_CNT_LEN-1:0]  idx
    );
        return {line[ICACHE_ADDR_LEN-1:ICACHE_OFFSET_LEN], idx, 2'b00};
    endfunction

endpackage

// File: rtl/ysyx_23060236_icache_refill.sv
// I-cache refill controller: one AXI4 INCR line burst per miss, buffered, then streamed to the fill port.
// Latency: miss to refill_done = 18 cycles with a zero-wait slave (1 AR + 8 R + 8 WRITE + 1 DONE).
// Backpressure: arvalid/araddr held until arready; rready held through the burst; the fill port never stalls.
//
// Ports:
//   clock, reset (async, active-low)
//   miss_valid/miss_addr  : IFU miss request (level, held until refill_done)
//   inst_fencei           : fence.i pulse; discards an in-flight refill
//   refill_busy/done/error: status towards the IFU
//   icache_awaddr/wdata/wvalid : cache fill port, one word per cycle
//   io_master_ar* / io_master_r* : AXI4 read channels towards the arbiter
//
// Nothing reaches the cache until the whole line has arrived cleanly, so an
// erroneous or discarded burst never leaves a partially written line behind.
module ysyx_23060236_icache_refill
    import ysyx_23060236_icache_refill_pkg::*;
(
    input  logic                       clock,
    input  logic                       reset,

    input  logic                       miss_valid,
    input  logic [ICACHE_ADDR_LEN-1:0] miss_addr,
    input  logic                       inst_fencei,
    output logic                       refill_busy,
    output logic                       refill_done,
    output logic                       refill_error,

    output logic [ICACHE_ADDR_LEN-1:0] icache_awaddr,
    output logic [ICACHE_DATA_LEN-1:0] icache_wdata,
    output logic                       icache_wvalid,

    output logic [31:0]                io_master_araddr,
    output logic                       io_master_arvalid,
    input  logic                       io_master_arready,
    output logic [3:0]                 io_master_arid,
    output logic [7:0]                 io_master_arlen,
    output logic [2:0]                 io_master_arsize,
    output logic [1:0]                 io_master_arburst,
    input  logic                       io_master_rvalid,
    output logic                       io_master_rready,
    input  logic [ICACHE_DATA_LEN-1:0] io_master_rdata,
    input  logic [1:0]                 io_master_rresp,
    input  logic                       io_master_rlast,
    input  logic [3:0]                 io_master_rid
);

    localparam logic [ICACHE_CNT_LEN-1:0] LAST_BEAT = ICACHE_CNT_LEN'(ICACHE_BLOCK_SIZE - 1);
    localparam logic [ICACHE_CNT_LEN-1:0] FIRST_BEAT = '0;

    refill_state_t              state_q;
    logic [ICACHE_CNT_LEN-1:0]  cnt_q;
    logic [ICACHE_ADDR_LEN-1:0] line_q;
    logic                       err_q;
    logic                       discard_q;

    logic                       arvalid_q;
    logic [31:0]                araddr_q;
    logic                       rready_q;
    logic                       wvalid_q;
    logic [ICACHE_ADDR_LEN-1:0] awaddr_q;
    logic [ICACHE_DATA_LEN-1:0] wdata_q;
    logic                       done_q;
    logic                       error_q;

    logic [ICACHE_DATA_LEN-1:0] buf_q [ICACHE_BLOCK_SIZE];

    logic                       beat;
    logic                       beat_err;
    logic                       err_d;
    logic                       discard_d;
    logic [ICACHE_CNT_LEN-1:0]  cnt_nxt;

    // The transaction id and the in-line offset bits carry no information here.
    logic unused_ok;
    assign unused_ok = ^{io_master_rid, miss_addr[ICACHE_OFFSET_LEN-1:0]};

    always_comb begin
        beat      = 1'b0;
        beat_err  = 1'b0;
        err_d     = err_q;
        discard_d = discard_q;
        cnt_nxt   = cnt_q + 1'b1;

        beat = (state_q == S_R) && io_master_rvalid && rready_q;
        // A beat is bad if the slave reports an error, or if rlast does not
        // line up with the final word of the line (short or long burst).
        beat_err = (io_master_rresp != AXI_RESP_OKAY) ||
                   (io_master_rlast != (cnt_q == LAST_BEAT));
        err_d = err_q | (beat & beat_err);
        // fence.i while the burst is in flight poisons the line; the burst
        // still drains so the bus is left clean.
        discard_d = discard_q |
                    (inst_fencei && ((state_q == S_AR) || (state_q == S_R)));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            line_q    <= '0;
            err_q     <= 1'b0;
            discard_q <= 1'b0;
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            rready_q  <= 1'b0;
            wvalid_q  <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (miss_valid) begin
                        line_q    <= line_base(miss_addr);
                        araddr_q  <= ICACHE_MEM_BASE | 32'(line_base(miss_addr));
                        arvalid_q <= 1'b1;
                        state_q   <= S_AR;
                    end
                end

                S_AR: begin
                    discard_q <= discard_d;
                    if (io_master_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        cnt_q     <= '0;
                        state_q   <= S_R;
                    end
                end

                S_R: begin
                    discard_q <= discard_d;
                    err_q     <= err_d;
                    if (beat) begin
                        cnt_q <= cnt_nxt;
                        if (io_master_rlast) begin
                            rready_q <= 1'b0;
                            if (err_d || discard_d) begin
                                done_q  <= 1'b1;
                                error_q <= err_d;
                                state_q <= S_DONE;
                            end else begin
                                // Word 0 was stored on an earlier beat, so it
                                // can be presented in the first WRITE cycle.
                                cnt_q    <= '0;
                                wvalid_q <= 1'b1;
                                awaddr_q <= word_addr(line_q, FIRST_BEAT);
                                wdata_q  <= buf_q[0];
                                state_q  <= S_WRITE;
                            end
                        end
                    end
                end

                S_WRITE: begin
                    if (inst_fencei || (cnt_q == LAST_BEAT)) begin
                        wvalid_q <= 1'b0;
                        done_q   <= 1'b1;
                        error_q  <= err_q;
                        state_q  <= S_DONE;
                    end else begin
                        cnt_q    <= cnt_nxt;
                        awaddr_q <= word_addr(line_q, cnt_nxt);
                        wdata_q  <= buf_q[cnt_nxt];
                    end
                end

                S_DONE: begin
                    done_q    <= 1'b0;
                    error_q   <= 1'b0;
                    err_q     <= 1'b0;
                    discard_q <= 1'b0;
                    state_q   <= S_IDLE;
                end

                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Line buffer: no reset needed, contents are only consumed after a full
    // clean burst has overwritten every entry.
    always_ff @(posedge clock) begin
        if (beat) begin
            buf_q[cnt_q] <= io_master_rdata;
        end
    end

    assign refill_busy   = (state_q != S_IDLE);
    assign refill_done   = done_q;
    assign refill_error  = error_q;

    // fence.i in the WRITE state must suppress the word presented that very
    // cycle, so the strobe is gated rather than waiting for the next edge.
    assign icache_wvalid = wvalid_q & ~inst_fencei;
    assign icache_awaddr = awaddr_q;
    assign icache_wdata  = wdata_q;

    assign io_master_araddr  = araddr_q;
    assign io_master_arvalid = arvalid_q;
    assign io_master_arid    = 4'd0;
    assign io_master_arlen   = 8'(ICACHE_BLOCK_SIZE - 1);
    assign io_master_arsize  = AXI_SIZE_4B;
    assign io_master_arburst = AXI_BURST_INCR;
    assign io_master_rready  = rready_q;

endmodule

// File: tb/tb_ysyx_23060236_icache_refill.sv
module tb_ysyx_23060236_icache_refill;

    logic        clock = 1'b0;
    logic        reset;
    logic        miss_valid;
    logic [24:0] miss_addr;
    logic        inst_fencei;
    logic        refill_busy, refill_done, refill_error;
    logic [24:0] icache_awaddr;
    logic [31:0] icache_wdata;
    logic        icache_wvalid;
    logic [31:0] io_master_araddr;
    logic        io_master_arvalid, io_master_arready;
    logic [3:0]  io_master_arid;
    logic [7:0]  io_master_arlen;
    logic [2:0]  io_master_arsize;
    logic [1:0]  io_master_arburst;
    logic        io_master_rvalid, io_master_rready;
    logic [31:0] io_master_rdata;
    logic [1:0]  io_master_rresp;
    logic        io_master_rlast;
    logic [3:0]  io_master_rid;

    always #5 clock = ~clock;

    ysyx_23060236_icache_refill dut (
        .clock(clock), .reset(reset),
        .miss_valid(miss_valid), .miss_addr(miss_addr), .inst_fencei(inst_fencei),
        .refill_busy(refill_busy), .refill_done(refill_done), .refill_error(refill_error),
        .icache_awaddr(icache_awaddr), .icache_wdata(icache_wdata), .icache_wvalid(icache_wvalid),
        .io_master_araddr(io_master_araddr), .io_master_arvalid(io_master_arvalid),
        .io_master_arready(io_master_arready), .io_master_arid(io_master_arid),
        .io_master_arlen(io_master_arlen), .io_master_arsize(io_master_arsize),
        .io_master_arburst(io_master_arburst), .io_master_rvalid(io_master_rvalid),
        .io_master_rready(io_master_rready), .io_master_rdata(io_master_rdata),
        .io_master_rresp(io_master_rresp), .io_master_rlast(io_master_rlast),
        .io_master_rid(io_master_rid)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clock) cyc++;

    // Slave configuration
    int          cfg_ar_delay = 0;
    int          cfg_gap = 0;
    int          cfg_err_beat = -1;
    int          cfg_last_beat = 7;
    logic [31:0] cfg_base = 32'h1000;
    int          r_beats = 0;

    // Monitor records
    logic [24:0] wr_addr[$];
    logic [31:0] wr_data[$];
    int          done_n = 0;
    logic        done_err = 1'b0;
    logic [31:0] ar_cap = '0;
    int          ar_unstable = 0;

    // AXI read slave: decides handshakes from negedge samples, drives #1 after posedge.
    initial begin
        bit ar_f, r_f, in_burst;
        int beat, ar_wait;
        in_burst = 0; beat = 0; ar_wait = 0;
        io_master_arready = 0; io_master_rvalid = 0; io_master_rdata = '0;
        io_master_rresp = 2'b00; io_master_rlast = 0; io_master_rid = 4'd0;
        forever begin
            @(negedge clock);
            ar_f = io_master_arvalid && io_master_arready;
            r_f  = io_master_rvalid && io_master_rready;
            @(posedge clock);
            #1;
            if (!reset) begin
                io_master_arready = 0; io_master_rvalid = 0; io_master_rlast = 0;
                io_master_rresp = 2'b00; in_burst = 0; ar_wait = 0; beat = 0;
            end else begin
                if (ar_f) begin
                    io_master_arready = 0; in_burst = 1; beat = 0; ar_wait = 0;
                end
                if (r_f) begin
                    r_beats++;
                    beat++;
                    if (io_master_rlast) in_burst = 0;
                end
                if (!in_burst && io_master_arvalid && !io_master_arready) begin
                    if (ar_wait >= cfg_ar_delay) io_master_arready = 1;
                    else ar_wait++;
                end
                if (in_burst && !(cfg_gap != 0 && io_master_rvalid)) begin
                    io_master_rvalid = 1;
                    io_master_rdata  = cfg_base + beat;
                    io_master_rresp  = (beat == cfg_err_beat) ? 2'b10 : 2'b00;
                    io_master_rlast  = (beat == cfg_last_beat);
                end else begin
                    io_master_rvalid = 0; io_master_rlast = 0; io_master_rresp = 2'b00;
                end
            end
        end
    end

    // Passive monitor
    initial begin
        bit pend;
        logic [31:0] pend_addr;
        pend = 0; pend_addr = '0;
        forever begin
            @(negedge clock);
            if (!reset) begin
                pend = 0;
            end else begin
                if (pend && (!io_master_arvalid || io_master_araddr != pend_addr)) ar_unstable++;
                if (io_master_arvalid && io_master_arready) ar_cap = io_master_araddr;
                pend = io_master_arvalid && !io_master_arready;
                pend_addr = io_master_araddr;
                if (icache_wvalid) begin
                    wr_addr.push_back(icache_awaddr);
                    wr_data.push_back(icache_wdata);
                end
                if (refill_done) begin
                    done_n++;
                    done_err = refill_error;
                end
            end
        end
    end

    task automatic clear_mon();
        wr_addr.delete(); wr_data.delete();
        done_n = 0; done_err = 0; ar_cap = '0; ar_unstable = 0; r_beats = 0;
    endtask

    // Raise a miss and wait (bounded) for refill_done; lat is in cycles from the miss cycle.
    task automatic do_miss(input logic [24:0] a, output int lat, output bit to);
        int s;
        clear_mon();
        @(posedge clock); #1;
        miss_addr = a; miss_valid = 1; s = cyc; to = 1; lat = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clock);
            if (refill_done) begin lat = cyc - s; to = 0; break; end
        end
        miss_valid = 0;
        @(posedge clock); #1;
    endtask

    task automatic test_reset();
        reset = 0; miss_valid = 0; miss_addr = '0; inst_fencei = 0;
        #1;
        checks++; if (io_master_arvalid !== 1'b0) begin errors++; $display("FAIL rst_arvalid got %b exp 0", io_master_arvalid); end
        checks++; if (io_master_rready !== 1'b0) begin errors++; $display("FAIL rst_rready got %b exp 0", io_master_rready); end
        checks++; if (icache_wvalid !== 1'b0) begin errors++; $display("FAIL rst_wvalid got %b exp 0", icache_wvalid); end
        checks++; if (refill_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", refill_busy); end
        checks++; if ({refill_done, refill_error} !== 2'b00) begin errors++; $display("FAIL rst_done_err got %b exp 00", {refill_done, refill_error}); end
        checks++; if (icache_awaddr !== 25'd0 || icache_wdata !== 32'd0) begin errors++; $display("FAIL rst_fill got %h/%h exp 0/0", icache_awaddr, icache_wdata); end
        checks++; if (io_master_arlen !== 8'd7) begin errors++; $display("FAIL arlen got %0d exp 7", io_master_arlen); end
        checks++; if ({io_master_arid, io_master_arsize, io_master_arburst} !== {4'd0, 3'b010, 2'b01}) begin
            errors++; $display("FAIL ar_consts got %h/%b/%b exp 0/010/01", io_master_arid, io_master_arsize, io_master_arburst); end
        repeat (3) @(negedge clock);
        reset = 1;
        @(posedge clock); #1;
        checks++; if (refill_busy !== 1'b0) begin errors++; $display("FAIL post_rst_busy got %b exp 0", refill_busy); end
    endtask

    task automatic test_clean_miss();
        int lat; bit to;
        cfg_base = 32'h1000; cfg_ar_delay = 0; cfg_gap = 0; cfg_err_beat = -1; cfg_last_beat = 7;
        do_miss(25'h0000124, lat, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL clean_timeout got %b exp 0", to); end
        checks++; if (lat != 18) begin errors++; $display("FAIL clean_latency got %0d exp 18", lat); end
        checks++; if (ar_cap !== 32'hA000_0120) begin errors++; $display("FAIL clean_araddr got %h exp A0000120", ar_cap); end
        checks++; if (wr_addr.size() != 8) begin errors++; $display("FAIL clean_wcount got %0d exp 8", wr_addr.size()); end
        for (int i = 0; i < 8 && i < wr_addr.size(); i++) begin
            checks++; if (wr_addr[i] !== 25'h120 + 25'(4 * i)) begin errors++; $display("FAIL clean_awaddr[%0d] got %h exp %h", i, wr_addr[i], 25'h120 + 25'(4 * i)); end
            checks++; if (wr_data[i] !== 32'h1000 + 32'(i)) begin errors++; $display("FAIL clean_wdata[%0d] got %h exp %h", i, wr_data[i], 32'h1000 + 32'(i)); end
        end
        checks++; if (done_n != 1 || done_err !== 1'b0) begin errors++; $display("FAIL clean_done got n=%0d err=%b exp n=1 err=0", done_n, done_err); end
        checks++; if (refill_busy !== 1'b0) begin errors++; $display("FAIL clean_idle_busy got %b exp 0", refill_busy); end
    endtask

    task automatic test_backpressure();
        int lat; bit to;
        cfg_base = 32'h3000; cfg_ar_delay = 3; cfg_gap = 1;
        do_miss(25'h0000458, lat, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL bp_timeout got %b exp 0", to); end
        checks++; if (ar_unstable != 0) begin errors++; $display("FAIL bp_ar_stable got %0d exp 0", ar_unstable); end
        checks++; if (ar_cap !== 32'hA000_0440) begin errors++; $display("FAIL bp_araddr got %h exp A0000440", ar_cap); end
        checks++; if (lat != 28) begin errors++; $display("FAIL bp_latency got %0d exp 28", lat); end
        checks++; if (wr_addr.size() != 8) begin errors++; $display("FAIL bp_wcount got %0d exp 8", wr_addr.size()); end
        for (int i = 0; i < 8 && i < wr_addr.size(); i++) begin
            checks++; if (wr_addr[i] !== 25'h440 + 25'(4 * i) || wr_data[i] !== 32'h3000 + 32'(i)) begin
                errors++; $display("FAIL bp_word[%0d] got %h/%h exp %h/%h", i, wr_addr[i], wr_data[i], 25'h440 + 25'(4 * i), 32'h3000 + 32'(i)); end
        end
        cfg_ar_delay = 0; cfg_gap = 0;
    endtask

    task automatic test_bus_error();
        int lat; bit to;
        cfg_base = 32'h5000; cfg_err_beat = 5;
        do_miss(25'h0000600, lat, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL buserr_timeout got %b exp 0", to); end
        checks++; if (r_beats != 8) begin errors++; $display("FAIL buserr_drain got %0d exp 8", r_beats); end
        checks++; if (wr_addr.size() != 0) begin errors++; $display("FAIL buserr_wcount got %0d exp 0", wr_addr.size()); end
        checks++; if (done_n != 1 || done_err !== 1'b1) begin errors++; $display("FAIL buserr_done got n=%0d err=%b exp n=1 err=1", done_n, done_err); end
        cfg_err_beat = -1;
    endtask

    task automatic test_protocol_error();
        int lat; bit to;
        cfg_last_beat = 3;
        do_miss(25'h0000700, lat, to);
        checks++; if (r_beats != 4) begin errors++; $display("FAIL proto_beats got %0d exp 4", r_beats); end
        checks++; if (lat != 6) begin errors++; $display("FAIL proto_latency got %0d exp 6", lat); end
        checks++; if (wr_addr.size() != 0) begin errors++; $display("FAIL proto_wcount got %0d exp 0", wr_addr.size()); end
        checks++; if (done_n != 1 || done_err !== 1'b1) begin errors++; $display("FAIL proto_done got n=%0d err=%b exp n=1 err=1", done_n, done_err); end
        cfg_last_beat = 7;
    endtask

    task automatic test_fence_in_r();
        int lat; bit to;
        cfg_base = 32'h6000;
        fork
            do_miss(25'h0000800, lat, to);
            begin
                for (int i = 0; i < 100; i++) begin @(posedge clock); #2; if (r_beats == 2) break; end
                inst_fencei = 1;
                @(posedge clock); #2;
                inst_fencei = 0;
            end
        join
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL fence_r_timeout got %b exp 0", to); end
        checks++; if (r_beats != 8) begin errors++; $display("FAIL fence_r_drain got %0d exp 8", r_beats); end
        checks++; if (wr_addr.size() != 0) begin errors++; $display("FAIL fence_r_wcount got %0d exp 0", wr_addr.size()); end
        checks++; if (done_n != 1 || done_err !== 1'b0) begin errors++; $display("FAIL fence_r_done got n=%0d err=%b exp n=1 err=0", done_n, done_err); end
    endtask

    task automatic test_fence_in_write();
        int lat; bit to;
        cfg_base = 32'h7000;
        fork
            do_miss(25'h0000900, lat, to);
            begin
                for (int i = 0; i < 100; i++) begin @(posedge clock); #2; if (wr_addr.size() == 3) break; end
                inst_fencei = 1;
                @(posedge clock); #2;
                inst_fencei = 0;
            end
        join
        checks++; if (wr_addr.size() != 3) begin errors++; $display("FAIL fence_w_wcount got %0d exp 3", wr_addr.size()); end
        checks++; if (lat != 14) begin errors++; $display("FAIL fence_w_latency got %0d exp 14", lat); end
        checks++; if (wr_addr.size() == 3 && wr_data[2] !== 32'h7002) begin errors++; $display("FAIL fence_w_data2 got %h exp 7002", wr_data[2]); end
        checks++; if (done_n != 1 || done_err !== 1'b0) begin errors++; $display("FAIL fence_w_done got n=%0d err=%b exp n=1 err=0", done_n, done_err); end
    endtask

    task automatic test_async_reset();
        int lat; bit to;
        cfg_base = 32'h2000;
        clear_mon();
        @(posedge clock); #1;
        miss_addr = 25'h0000A00; miss_valid = 1;
        for (int i = 0; i < 100; i++) begin @(posedge clock); #2; if (wr_addr.size() == 4) break; end
        #1 reset = 0;
        #1;
        checks++; if (icache_wvalid !== 1'b0 || refill_busy !== 1'b0) begin errors++; $display("FAIL arst_wvalid_busy got %b/%b exp 0/0", icache_wvalid, refill_busy); end
        checks++; if (icache_awaddr !== 25'd0 || icache_wdata !== 32'd0) begin errors++; $display("FAIL arst_fill got %h/%h exp 0/0", icache_awaddr, icache_wdata); end
        checks++; if ({refill_done, refill_error, io_master_arvalid, io_master_rready} !== 4'b0000) begin
            errors++; $display("FAIL arst_ctrl got %b exp 0000", {refill_done, refill_error, io_master_arvalid, io_master_rready}); end
        miss_valid = 0;
        repeat (2) @(negedge clock);
        reset = 1;
        do_miss(25'h1ABCDE8, lat, to);
        checks++; if (to !== 1'b0 || lat != 18) begin errors++; $display("FAIL arst_refill got to=%b lat=%0d exp to=0 lat=18", to, lat); end
        checks++; if (ar_cap !== 32'hA1AB_CDE0) begin errors++; $display("FAIL arst_araddr got %h exp A1ABCDE0", ar_cap); end
        checks++; if (wr_addr.size() != 8) begin errors++; $display("FAIL arst_wcount got %0d exp 8", wr_addr.size()); end
        for (int i = 0; i < 8 && i < wr_addr.size(); i++) begin
            checks++; if (wr_addr[i] !== 25'h1ABCDE0 + 25'(4 * i) || wr_data[i] !== 32'h2000 + 32'(i)) begin
                errors++; $display("FAIL arst_word[%0d] got %h/%h exp %h/%h", i, wr_addr[i], wr_data[i], 25'h1ABCDE0 + 25'(4 * i), 32'h2000 + 32'(i)); end
        end
    endtask

    initial begin
        test_reset();
        test_clean_miss();
        test_backpressure();
        test_bus_error();
        test_protocol_error();
        test_fence_in_r();
        test_fence_in_write();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
